nn_mem_manager: RTL and testbench
=================================

// Module: nn_mem_manager
// PURPOSE
//  Parametrised memory manager for the neural-network datapath. Holds three register-file regions:
//  neuron data, weights and biases. Serves single-beat reads/writes and auto-incrementing read bursts
//  over a valid/ready request channel. Flags out-of-range accesses. Sits between the host/Wishbone
//  bridge and the neuron compute engine.
// PARAMETERS
//  DATA_W      16      data word width
//  ADDR_W      16      request address width
//  N_DATA      6       neuron-data region depth (words)
//  N_WEIGHT    18      weight region depth (words)
//  N_BIAS      7       bias region depth (words)
//  WEIGHT_BASE 'h0100  first address of weight region; data region is [0, WEIGHT_BASE)
//  BIAS_BASE   'h0200  first address of bias region; bias region is [BIAS_BASE, 2^ADDR_W)
//  LEN_W       5       burst-length field width
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       asynchronous, active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       request accepted when req_valid && req_ready
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  start address
//  req_wdata  in   DATA_W  write data
//  req_len    in   LEN_W   read burst: beats-1 (0 = single); ignored for writes
//  rsp_valid  out  1       one-cycle response strobe per beat (reads and writes)
//  rsp_rdata  out  DATA_W  read data (0 for writes and errors)
//  rsp_err    out  1       beat was out of range
//  busy       out  1       FSM not in IDLE
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0; req_ready=0 while rst is high, 1 in the
//    first cycle after release. Memory arrays are not reset; contents are X until written.
//  - Decode: offset = addr - region base.
//    offset >= region depth -> err: write dropped, rsp_rdata=0, rsp_err=1.
//  - FSM states: IDLE, BURST (plus CLEAR, see CONFIGURATION). req_ready = (state==IDLE).
//  - IDLE, accepted write: memory updated at the same edge. Next cycle rsp_valid=1, rsp_rdata=0,
//    rsp_err as decoded. Stays in IDLE.
//  - IDLE, accepted read, req_len=0: next cycle rsp_valid=1 with rsp_rdata/rsp_err. Latency 1.
//    Stays in IDLE, so back-to-back requests give one response per cycle.
//  - IDLE, accepted read, req_len=L>0: first beat as a single read. Go to BURST with counter=L and
//    addr+1. BURST issues one beat per cycle (address +1 each), decrementing the counter. Return to
//    IDLE after the beat issued with counter==1. Total L+1 consecutive rsp_valid pulses.
//    No response backpressure: the consumer must sink every beat.
//  - Burst crossing a region end: the beats past the end report rsp_err=1, rdata=0, and the burst
//    continues. Addresses entering the next region are decoded normally. Address wraps modulo
//    2^ADDR_W.
//  - Requests in BURST are not accepted (req_ready=0); the requester must hold req_valid.
//  - rsp_valid is 0 in any cycle with no beat; rsp_rdata/rsp_err hold their last value.
//  - rst asserted mid-burst: burst aborted immediately, no further rsp_valid, FSM to IDLE.
// CONFIGURATION
//  NNMEM_CLEAR_EN defined:
//  - Adds input port clr_start (1 bit) and state CLEAR.
//  - clr_start high in IDLE (priority over req_valid, which is not accepted that cycle) -> CLEAR.
//  - CLEAR writes 0 to index i of every region whose depth > i, one index per cycle, for
//    i = 0..max(N_DATA,N_WEIGHT,N_BIAS)-1, then returns to IDLE.
//  - busy=1 and req_ready=0 during CLEAR. No rsp_valid is generated.
//  - clr_start is ignored outside IDLE.
//  NNMEM_CLEAR_EN undefined: no clr_start port, no CLEAR state; memories only change by writes.
// TESTING
//  1. Reset release -> rsp_valid=0, busy=0, req_ready=1 next cycle. Write 'h1234 @'h0003, then read
//     @'h0003 -> rsp_valid one cycle after accept, rdata='h1234, err=0.
//  2. Write 'hAAAA @'h0111 (weight 17), 'h5555 @'h0206 (bias 6); read both -> correct data, err=0.
//     Read @'h0112 and @'h0007 -> err=1, rdata=0. Write @'h0112 -> err=1, no memory change.
//  3. Fill weights 0..17 with 'h0100+i; read @'h0100 len=17 -> 18 consecutive beats 'h0100..'h0111,
//     err=0; req_ready=0 for 17 cycles, busy high.
//  4. Read @'h0004 len=3 -> beats data[4], data[5], err, err; FSM back to IDLE after 4 beats.
//  5. Start len=10 burst, assert rst after beat 3 -> no further rsp_valid, outputs zero. After
//     release a single read succeeds.
//  6. (NNMEM_CLEAR_EN) write non-zero everywhere, pulse clr_start -> busy=1 for 18 cycles, then
//     every valid address reads 0.

Source files
------------

// File: rtl/nn_mem_manager.sv
// Three-region register-file memory manager (neuron data, weights, biases) with single-beat and burst-read access.
// Optional build macro NNMEM_CLEAR_EN adds clr_start and a CLEAR state that zeroes all regions.
module nn_mem_manager #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter int                N_DATA      = 6,
    parameter int                N_WEIGHT    = 18,
    parameter int                N_BIAS      = 7,
    parameter logic [ADDR_W-1:0] WEIGHT_BASE = ADDR_W'('h0100),
    parameter logic [ADDR_W-1:0] BIAS_BASE   = ADDR_W'('h0200),
    parameter int                LEN_W       = 5
) (
    input  logic              clk,
    input  logic              rst,
`ifdef NNMEM_CLEAR_EN
    input  logic              clr_start,
`endif
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int DI_W = (N_DATA   > 1) ? $clog2(N_DATA)   : 1;
    localparam int WI_W = (N_WEIGHT > 1) ? $clog2(N_WEIGHT) : 1;
    localparam int BI_W = (N_BIAS   > 1) ? $clog2(N_BIAS)   : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST
`ifdef NNMEM_CLEAR_EN
        , ST_CLEAR
`endif
    } state_e;

    typedef enum logic [1:0] {REG_DATA, REG_WEIGHT, REG_BIAS} region_e;

    typedef struct packed {
        region_e           region;
        logic [ADDR_W-1:0] offset;
        logic              err;
    } decode_t;

    function automatic decode_t decode(input logic [ADDR_W-1:0] addr);
        decode_t d;
        if (addr < WEIGHT_BASE) begin
            d.region = REG_DATA;
            d.offset = addr;
            d.err    = (addr >= ADDR_W'(N_DATA));
        end else if (addr < BIAS_BASE) begin
            d.region = REG_WEIGHT;
            d.offset = addr - WEIGHT_BASE;
            d.err    = (d.offset >= ADDR_W'(N_WEIGHT));
        end else begin
            d.region = REG_BIAS;
            d.offset = addr - BIAS_BASE;
            d.err    = (d.offset >= ADDR_W'(N_BIAS));
        end
        return d;
    endfunction

    logic [DATA_W-1:0] data_mem   [0:N_DATA-1];
    logic [DATA_W-1:0] weight_mem [0:N_WEIGHT-1];
    logic [DATA_W-1:0] bias_mem   [0:N_BIAS-1];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LEN_W-1:0]  cnt_q,   cnt_d;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q, rdata_d;
    logic              rsp_err_q;

    logic              beat_valid;
    logic [ADDR_W-1:0] beat_addr;
    logic              wr_en;
    decode_t           dec;

`ifdef NNMEM_CLEAR_EN
    localparam int MAX_NW = (N_DATA > N_WEIGHT) ? N_DATA : N_WEIGHT;
    localparam int MAX_N  = (MAX_NW > N_BIAS) ? MAX_NW : N_BIAS;
    localparam int CLR_W  = (MAX_N > 1) ? $clog2(MAX_N) : 1;

    logic [CLR_W-1:0] clr_idx_q, clr_idx_d;
`endif

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        beat_valid = 1'b0;
        beat_addr  = addr_q;
        wr_en      = 1'b0;
        req_ready  = (state_q == ST_IDLE) && !rst;
`ifdef NNMEM_CLEAR_EN
        clr_idx_d  = clr_idx_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef NNMEM_CLEAR_EN
                if (clr_start) begin
                    req_ready = 1'b0;
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end else
`endif
                if (req_valid && req_ready) begin
                    beat_valid = 1'b1;
                    beat_addr  = req_addr;
                    if (req_we) begin
                        wr_en = 1'b1;
                    end else if (req_len != '0) begin
                        state_d = ST_BURST;
                        addr_d  = req_addr + 1'b1;
                        cnt_d   = req_len;
                    end
                end
            end
            ST_BURST: begin
                beat_valid = 1'b1;
                addr_d     = addr_q + 1'b1;
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == LEN_W'(1)) state_d = ST_IDLE;
            end
`ifdef NNMEM_CLEAR_EN
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == CLR_W'(MAX_N - 1)) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign dec  = decode(beat_addr);
    assign busy = (state_q != ST_IDLE);

    always_comb begin
        rdata_d = '0;
        if (!wr_en && !dec.err) begin
            case (dec.region)
                REG_DATA:   rdata_d = data_mem[dec.offset[DI_W-1:0]];
                REG_WEIGHT: rdata_d = weight_mem[dec.offset[WI_W-1:0]];
                REG_BIAS:   rdata_d = bias_mem[dec.offset[BI_W-1:0]];
                default:    rdata_d = '0;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef NNMEM_CLEAR_EN
            clr_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= beat_valid;
            if (beat_valid) begin
                rsp_rdata_q <= rdata_d;
                rsp_err_q   <= dec.err;
            end
`ifdef NNMEM_CLEAR_EN
            clr_idx_q   <= clr_idx_d;
`endif
        end
    end

    // NOTE: memory arrays have no reset; contents are undefined until written, which keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !dec.err) begin
            case (dec.region)
                REG_DATA:   data_mem[dec.offset[DI_W-1:0]]   <= req_wdata;
                REG_WEIGHT: weight_mem[dec.offset[WI_W-1:0]] <= req_wdata;
                REG_BIAS:   bias_mem[dec.offset[BI_W-1:0]]   <= req_wdata;
                default: ;
            endcase
        end
`ifdef NNMEM_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            if (clr_idx_q < CLR_W'(N_DATA))   data_mem[clr_idx_q[DI_W-1:0]]   <= '0;
            if (clr_idx_q < CLR_W'(N_WEIGHT)) weight_mem[clr_idx_q[WI_W-1:0]] <= '0;
            if (clr_idx_q < CLR_W'(N_BIAS))   bias_mem[clr_idx_q[BI_W-1:0]]   <= '0;
        end
`endif
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_nn_mem_manager.sv
// Directed self-checking bench for nn_mem_manager; covers reset, region decode, bursts, reset abort and optional clear.
`timescale 1ns/1ps
module tb_nn_mem_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [4:0]  req_len;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
`ifdef NNMEM_CLEAR_EN
    logic        clr_start;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nn_mem_manager dut (
        .clk       (clk),
        .rst       (rst),
`ifdef NNMEM_CLEAR_EN
        .clr_start (clr_start),
`endif
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_len   (req_len),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    // Drives one request for one clock edge; returns 1ns after the accepting edge.
    task automatic issue(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [4:0] len);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_len   = len;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_len   = '0;
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL in_reset: ready=%b valid=%b busy=%b want 0 0 0", req_ready, rsp_valid, busy);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL after_release: ready=%b valid=%b busy=%b rdata=%h err=%b want 1 0 0 0000 0",
                     req_ready, rsp_valid, busy, rsp_rdata, rsp_err);
        end
        @(posedge clk); #1;
        issue(1'b1, 16'h0003, 16'h1234, 5'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL write_rsp: valid=%b rdata=%h err=%b want 1 0000 0", rsp_valid, rsp_rdata, rsp_err);
        end
        issue(1'b0, 16'h0003, 16'h0, 5'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL read_0003: valid=%b rdata=%h err=%b want 1 1234 0", rsp_valid, rsp_rdata, rsp_err);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL idle_hold: valid=%b rdata=%h want 0 1234", rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_regions;
        issue(1'b1, 16'h0111, 16'hAAAA, 5'd0);
        issue(1'b1, 16'h0206, 16'h5555, 5'd0);
        issue(1'b0, 16'h0111, 16'h0, 5'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hAAAA || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL read_w17: valid=%b rdata=%h err=%b want 1 aaaa 0", rsp_valid, rsp_rdata, rsp_err);
        end
        issue(1'b0, 16'h0206, 16'h0, 5'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h5555 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL read_b6: valid=%b rdata=%h err=%b want 1 5555 0", rsp_valid, rsp_rdata, rsp_err);
        end
        issue(1'b0, 16'h0112, 16'h0, 5'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL read_oor_w: valid=%b rdata=%h err=%b want 1 0000 1", rsp_valid, rsp_rdata, rsp_err);
        end
        issue(1'b0, 16'h0007, 16'h0, 5'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL read_oor_d: valid=%b rdata=%h err=%b want 1 0000 1", rsp_valid, rsp_rdata, rsp_err);
        end
        issue(1'b1, 16'h0112, 16'hDEAD, 5'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0 || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL write_oor: valid=%b rdata=%h err=%b want 1 0000 1", rsp_valid, rsp_rdata, rsp_err);
        end
        issue(1'b0, 16'h0111, 16'h0, 5'd0);
        checks++;
        if (rsp_rdata !== 16'hAAAA || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL w17_intact: rdata=%h err=%b want aaaa 0", rsp_rdata, rsp_err);
        end
        issue(1'b0, 16'h0003, 16'h0, 5'd0);
        checks++;
        if (rsp_rdata !== 16'h1234 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL d3_intact: rdata=%h err=%b want 1234 0", rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_burst;
        logic [15:0] exp;
        for (int i = 0; i < 18; i++) issue(1'b1, 16'h0100 + 16'(i), 16'h0100 + 16'(i), 5'd0);
        issue(1'b0, 16'h0100, 16'h0, 5'd17);
        for (int i = 0; i < 18; i++) begin
            exp = 16'h0100 + 16'(i);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL burst_beat%0d: valid=%b rdata=%h err=%b want 1 %h 0",
                         i, rsp_valid, rsp_rdata, rsp_err, exp);
            end
            checks++;
            if (i < 17 && (req_ready !== 1'b0 || busy !== 1'b1)) begin
                errors++;
                $display("FAIL burst_busy%0d: ready=%b busy=%b want 0 1", i, req_ready, busy);
            end else if (i == 17 && (req_ready !== 1'b1 || busy !== 1'b0)) begin
                errors++;
                $display("FAIL burst_done: ready=%b busy=%b want 1 0", req_ready, busy);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL burst_extra_beat: valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_data [4];
        logic        exp_err  [4];
        issue(1'b1, 16'h0004, 16'h0404, 5'd0);
        issue(1'b1, 16'h0005, 16'h0505, 5'd0);
        exp_data = '{16'h0404, 16'h0505, 16'h0000, 16'h0000};
        exp_err  = '{1'b0, 1'b0, 1'b1, 1'b1};
        issue(1'b0, 16'h0004, 16'h0, 5'd3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_data[i] || rsp_err !== exp_err[i]) begin
                errors++;
                $display("FAIL cross_beat%0d: valid=%b rdata=%h err=%b want 1 %h %b",
                         i, rsp_valid, rsp_rdata, rsp_err, exp_data[i], exp_err[i]);
            end
            if (i == 3) begin
                checks++;
                if (busy !== 1'b0 || req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL cross_idle: busy=%b ready=%b want 0 1", busy, req_ready);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL cross_extra_beat: valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_reset_abort;
        issue(1'b0, 16'h0100, 16'h0, 5'd10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0102 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_beat3: valid=%b rdata=%h busy=%b want 1 0102 1", rsp_valid, rsp_rdata, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs: valid=%b rdata=%h err=%b busy=%b ready=%b want 0 0000 0 0 0",
                     rsp_valid, rsp_rdata, rsp_err, busy, req_ready);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_resume: valid=%b busy=%b want 0 0", rsp_valid, busy);
        end
        issue(1'b0, 16'h0003, 16'h0, 5'd0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_read: valid=%b rdata=%h err=%b want 1 1234 0", rsp_valid, rsp_rdata, rsp_err);
        end
    endtask

`ifdef NNMEM_CLEAR_EN
    task automatic test_clear;
        int cycles;
        for (int i = 0; i < 6; i++)  issue(1'b1, 16'h0000 + 16'(i), 16'hF000 + 16'(i), 5'd0);
        for (int i = 0; i < 18; i++) issue(1'b1, 16'h0100 + 16'(i), 16'hE000 + 16'(i), 5'd0);
        for (int i = 0; i < 7; i++)  issue(1'b1, 16'h0200 + 16'(i), 16'hD000 + 16'(i), 5'd0);
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL clear_ready: ready=%b valid=%b want 0 0", req_ready, rsp_valid);
            end
            cycles++;
            @(posedge clk); #1;
        end
        checks++;
        if (cycles != 18) begin
            errors++;
            $display("FAIL clear_cycles: got %0d want 18", cycles);
        end
        for (int i = 0; i < 31; i++) begin
            logic [15:0] a;
            a = (i < 6) ? 16'(i) : (i < 24) ? 16'h0100 + 16'(i - 6) : 16'h0200 + 16'(i - 24);
            issue(1'b0, a, 16'h0, 5'd0);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h0 || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL clear_read_%h: valid=%b rdata=%h err=%b want 1 0000 0",
                         a, rsp_valid, rsp_rdata, rsp_err);
            end
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_len   = '0;
`ifdef NNMEM_CLEAR_EN
        clr_start = 1'b0;
`endif
        test_reset();
        test_regions();
        test_burst();
        test_back_to_back();
        test_reset_abort();
`ifdef NNMEM_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
